// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the RV32M divide/remainder unit.
//   - div_state_e : FSM state encoding (IDLE, CALC, FIX, DONE)
//   - DIV_ITERS   : number of restoring iterations (one quotient bit per cycle)
//   - ALU_*       : divide-class operation codes, mirroring the ALU encodings
//                   used by the execute stage
//   - is_div_op   : true for the four divide-class operation codes
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [15:0] ALU_DIV  = 16'h0010;
    localparam logic [15:0] ALU_DIVU = 16'h0011;
    localparam logic [15:0] ALU_REM  = 16'h0012;
    localparam logic [15:0] ALU_REMU = 16'h0013;

    function automatic logic is_div_op(input logic [15:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring iteration.
// Ports:
//   rem_in   [W-1:0] current partial remainder
//   quo_in   [W-1:0] dividend/quotient shift register (MSB shifts into rem)
//   divisor  [W-1:0] divisor magnitude
//   rem_out  [W-1:0] next partial remainder
//   quo_out  [W-1:0] next quotient shift register (new bit at LSB)
// -----------------------------------------------------------------------------
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic [DATA_WIDTH-1:0] quo_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic [DATA_WIDTH-1:0] quo_out
);

    logic [DATA_WIDTH-1:0] shifted_lo;
    logic [DATA_WIDTH:0]   trial;

    // The trial difference is one bit wider than the remainder: since the
    // partial remainder is always below the divisor, the extra bit is exactly
    // the sign of the subtraction.
    assign shifted_lo = {rem_in[DATA_WIDTH-2:0], quo_in[DATA_WIDTH-1]};
    assign trial      = {rem_in, quo_in[DATA_WIDTH-1]} - {1'b0, divisor};

    always_comb begin
        rem_out = shifted_lo;
        quo_out = {quo_in[DATA_WIDTH-2:0], 1'b0};
        if (!trial[DATA_WIDTH]) begin
            rem_out = trial[DATA_WIDTH-1:0];
            quo_out = {quo_in[DATA_WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient
// bit per cycle, valid/ready handshakes on request and response.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. reqReady is high only in IDLE; respValid is high only in
// DONE and, once raised, result and respValid hold until respReady is seen.
//
// Ports:
//   clk        rising-edge clock
//   rstN       asynchronous active-low reset
//   reqValid   request present          reqReady  unit idle, can accept
//   aluCtrl    operation code           a, b      dividend, divisor
//   respValid  result available         respReady consumer takes result
//   result     quotient or remainder    busy      state != IDLE
//   dbg_state  current FSM state
//
// Build option: DIV_EARLY_OUT_EN -- when defined, divide-by-zero and signed
// overflow are answered at the acceptance edge instead of after the full
// iteration; result values are the same either way.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_ITERS
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [15:0]           aluCtrl,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output div_state_e            dbg_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Value mandated for divide-by-zero and signed overflow.
    function automatic logic [DATA_WIDTH-1:0] special_value(
        input logic                  is_quot,
        input logic                  div_zero,
        input logic [DATA_WIDTH-1:0] a_val
    );
        if (div_zero) return is_quot ? {DATA_WIDTH{1'b1}} : a_val;
        return is_quot ? MIN_NEG : '0;
    endfunction

    div_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [15:0]           op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic                  q_neg;
    logic                  r_neg;
    logic                  div_zero_q;
    logic                  ovf_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  busy_q;

    // Request decode, evaluated against the live inputs in IDLE.
    logic                  req_is_div;
    logic                  req_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  req_div_zero;
    logic                  req_ovf;

    assign req_is_div   = is_div_op(aluCtrl);
    assign req_signed   = (aluCtrl == ALU_DIV) || (aluCtrl == ALU_REM);
    assign a_neg        = req_signed && a[DATA_WIDTH-1];
    assign b_neg        = req_signed && b[DATA_WIDTH-1];
    // Two's complement in DATA_WIDTH bits: |MIN_NEG| stays MIN_NEG and is
    // then treated as an unsigned magnitude.
    assign a_mag        = a_neg ? (~a + 1'b1) : a;
    assign b_mag        = b_neg ? (~b + 1'b1) : b;
    assign req_div_zero = (b == '0);
    assign req_ovf      = req_signed && (a == MIN_NEG) && (b == {DATA_WIDTH{1'b1}});

`ifdef DIV_EARLY_OUT_EN
    logic req_is_quot;
    assign req_is_quot = (aluCtrl == ALU_DIV) || (aluCtrl == ALU_DIVU);
`endif

    // Iteration datapath.
    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_quo;

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Sign / special-case correction applied in FIX.
    logic                  op_is_quot;
    logic [DATA_WIDTH-1:0] q_fixed;
    logic [DATA_WIDTH-1:0] r_fixed;
    logic [DATA_WIDTH-1:0] fix_value;

    assign op_is_quot = (op_q == ALU_DIV) || (op_q == ALU_DIVU);
    assign q_fixed    = q_neg ? (~quo_q + 1'b1) : quo_q;
    assign r_fixed    = r_neg ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        fix_value = op_is_quot ? q_fixed : r_fixed;
        if (div_zero_q || ovf_q) begin
            fix_value = special_value(op_is_quot, div_zero_q, a_q);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            a_q          <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            div_zero_q   <= 1'b0;
            ovf_q        <= 1'b0;
            result_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        op_q        <= aluCtrl;
                        a_q         <= a;
                        quo_q       <= a_mag;
                        dvs_q       <= b_mag;
                        rem_q       <= '0;
                        q_neg       <= a_neg ^ b_neg;
                        r_neg       <= a_neg;
                        div_zero_q  <= req_div_zero;
                        ovf_q       <= req_ovf;
                        cnt         <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (!req_is_div) begin
                            state        <= DONE;
                            result_q     <= '0;
                            resp_valid_q <= 1'b1;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (req_div_zero || req_ovf) begin
                            state        <= DONE;
                            result_q     <= special_value(req_is_quot, req_div_zero, a);
                            resp_valid_q <= 1'b1;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo_q <= step_quo;
                    rem_q <= step_rem;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    result_q     <= fix_value;
                    resp_valid_q <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (respReady) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign reqReady  = req_ready_q;
    assign respValid = resp_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign dbg_state = state;

endmodule
